// File: rtl/pc.sv
// Program counter for the single-cycle RISC-V core: a size-bit register that
// loads RESET_VALUE under synchronous active-low reset and otherwise advances by STEP.
module pc #(
    parameter int unsigned size        = 32'd32,
    parameter logic [31:0] STEP        = 32'd4,
    parameter              RESET_VALUE = 32'd0
) (
    input  logic            clk,
    input  logic            reset,
    output logic [size-1:0] count
);

    // Parameters are cast to the counter width, so narrow counters drop upper bits
    // and wide counters zero-fill above the 32-bit parameter values.
    localparam logic [size-1:0] step_w  = size'(STEP);
    localparam logic [size-1:0] reset_w = size'(RESET_VALUE);

    logic [size-1:0] count_r;
    logic [size-1:0] count_next_s;

    // Next-state selection; the sum wraps modulo 2^size because carry-out is dropped.
    always_comb begin
        count_next_s = count_r;
        if (!reset) begin
            count_next_s = reset_w;
        end else begin
            count_next_s = count_r + step_w;
        end
    end

    // State register; reset is folded into count_next_s, so it acts only on the edge.
    always_ff @(posedge clk) begin
        count_r <= count_next_s;
    end

    assign count = count_r;

endmodule

// File: tb/tb_pc.sv
// Directed self-checking bench for pc: default, 4-bit wrap, 1024-bit wide,
// offset reset/step and near-top-of-range configurations share one clock and reset.
module tb_pc;

    logic           clk;
    logic           reset;
    logic [31:0]    cnt_a;
    logic [3:0]     cnt_n;
    logic [1023:0]  cnt_w;
    logic [31:0]    cnt_o;
    logic [31:0]    cnt_t;

    int total;
    int passed;

    pc u_def (.clk(clk), .reset(reset), .count(cnt_a));
    pc #(.size(32'd4)) u_nar (.clk(clk), .reset(reset), .count(cnt_n));
    pc #(.size(32'd1024)) u_wide (.clk(clk), .reset(reset), .count(cnt_w));
    pc #(.STEP(32'd8), .RESET_VALUE(32'h0000_1000)) u_off (.clk(clk), .reset(reset), .count(cnt_o));
    pc #(.RESET_VALUE(32'hFFFF_FFF4)) u_top (.clk(clk), .reset(reset), .count(cnt_t));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        total  = 0;
        passed = 0;
        reset  = 1'b0;

        // Power-up reset held for two edges.
        tick();
        chk("rst1_def",  1024'(cnt_a), 1024'(32'd0));
        chk("rst1_nar",  1024'(cnt_n), 1024'(4'd0));
        chk("rst1_wide", cnt_w,        1024'(32'd0));
        chk("rst1_off",  1024'(cnt_o), 1024'(32'h0000_1000));
        chk("rst1_top",  1024'(cnt_t), 1024'(32'hFFFF_FFF4));
        tick();
        chk("rst2_def",  1024'(cnt_a), 1024'(32'd0));
        chk("rst2_off",  1024'(cnt_o), 1024'(32'h0000_1000));

        // Five run edges.
        reset = 1'b1;
        tick();
        chk("run1_def",  1024'(cnt_a), 1024'(32'd4));
        chk("run1_nar",  1024'(cnt_n), 1024'(4'd4));
        chk("run1_off",  1024'(cnt_o), 1024'(32'h0000_1008));
        chk("run1_top",  1024'(cnt_t), 1024'(32'hFFFF_FFF8));
        tick();
        chk("run2_def",  1024'(cnt_a), 1024'(32'd8));
        chk("run2_nar",  1024'(cnt_n), 1024'(4'd8));
        chk("run2_off",  1024'(cnt_o), 1024'(32'h0000_1010));
        chk("run2_top",  1024'(cnt_t), 1024'(32'hFFFF_FFFC));
        tick();
        chk("run3_def",  1024'(cnt_a), 1024'(32'd12));
        chk("run3_nar",  1024'(cnt_n), 1024'(4'd12));
        chk("wrap_top",  1024'(cnt_t), 1024'(32'd0));
        tick();
        chk("run4_def",  1024'(cnt_a), 1024'(32'd16));
        chk("wrap_nar",  1024'(cnt_n), 1024'(4'd0));
        chk("run4_top",  1024'(cnt_t), 1024'(32'd4));
        tick();
        chk("run5_def",  1024'(cnt_a), 1024'(32'd20));
        chk("run5_nar",  1024'(cnt_n), 1024'(4'd4));
        chk("run5_wide", cnt_w,        1024'(32'd20));
        chk("wide_upper_zero", 1024'(cnt_w[1023:5] == 1019'd0), 1024'(1'b1));
        chk("wide_known",      1024'($isunknown(cnt_w)),        1024'(1'b0));

        // Reset again, then count up to 12.
        reset = 1'b0;
        tick();
        chk("rerst_def", 1024'(cnt_a), 1024'(32'd0));
        reset = 1'b1;
        tick();
        tick();
        tick();
        chk("pre_mid_def", 1024'(cnt_a), 1024'(32'd12));

        // Reset asserted 2 ns after an edge takes effect only on the next edge.
        #1;
        reset = 1'b0;
        #5;
        chk("mid_hold_def", 1024'(cnt_a), 1024'(32'd12));
        tick();
        chk("mid_rst_def",  1024'(cnt_a), 1024'(32'd0));
        chk("mid_rst_off",  1024'(cnt_o), 1024'(32'h0000_1000));
        reset = 1'b1;
        tick();
        chk("resume_def",   1024'(cnt_a), 1024'(32'd4));
        chk("resume_off",   1024'(cnt_o), 1024'(32'h0000_1008));

        // A reset glitch that does not straddle an edge is ignored.
        #2;
        reset = 1'b0;
        #3;
        reset = 1'b1;
        tick();
        chk("glitch_def",   1024'(cnt_a), 1024'(32'd8));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
